// File: rtl/whiz_graphics.sv
// Game-Boy-style graphics peripheral: OAM, VRAM and LCD registers on the shared 8-bit bus,
// dot/line/frame timing, and a background pixel stream with one cycle of latency.
module whiz_graphics #(
    parameter logic [15:0] OAM_LOC   = 16'hFE00,
    parameter logic [15:0] OAM_MASK  = 16'h00FF,
    parameter logic [15:0] VRAM_LOC  = 16'h8000,
    parameter logic [15:0] REG_LOC   = 16'hFF40,
    parameter int          DOTS_LINE = 456,
    parameter int          LINES     = 154,
    parameter int          VISIBLE   = 144,
    parameter int          WIDTH     = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] db_addr,
    input  logic [7:0]  db_wdata,
    input  logic        db_we,
    input  logic        db_re,
    output logic [7:0]  db_rdata,
    output logic        db_hit,
    output logic        drawline,
    output logic        render_complete,
    output logic        lcd_valid,
    output logic [7:0]  lcd_x,
    output logic [7:0]  lcd_y,
    output logic [1:0]  lcd_shade
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_LINE - 1);
    localparam logic [8:0] OAM_DOTS  = 9'd80;
    localparam logic [8:0] DRAW_END  = 9'(80 + WIDTH);
    localparam logic [7:0] LAST_LINE = 8'(LINES - 1);
    localparam logic [7:0] VIS_LINES = 8'(VISIBLE);

    function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] color);
        logic [1:0] res;
        case (color)
            2'd0:    res = pal[1:0];
            2'd1:    res = pal[3:2];
            2'd2:    res = pal[5:4];
            2'd3:    res = pal[7:6];
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    logic [7:0] oam_r  [0:255];
    logic [7:0] vram_r [0:8191];

    logic [7:0] lcdc_r, scy_r, scx_r, ly_r, lyc_r, bgp_r, obp0_r, obp1_r, wy_r, wx_r;
    logic [3:0] stat_r;
    logic [8:0] dot_r;

    logic       is_oam_s, is_vram_s, is_reg_s;
    logic [7:0] oam_idx_s;
    logic [7:0] reg_rdata_s;
    logic       reg_hit_s;
    logic [8:0] next_dot_s;
    logic [7:0] next_ly_s;
    logic [1:0] mode_s;

    assign is_oam_s  = (db_addr & ~OAM_MASK) == OAM_LOC;
    assign oam_idx_s = db_addr[7:0] & OAM_MASK[7:0];
    assign is_vram_s = db_addr[15:13] == VRAM_LOC[15:13];
    assign is_reg_s  = db_addr[15:4] == REG_LOC[15:4];

    // Register read mux; FF46 and anything past FF4B fall through as unmapped.
    always_comb begin
        reg_rdata_s = 8'hFF;
        reg_hit_s   = 1'b0;
        if (is_reg_s) begin
            reg_hit_s = 1'b1;
            case (db_addr[3:0])
                4'h0:    reg_rdata_s = lcdc_r;
                4'h1:    reg_rdata_s = {1'b0, stat_r, (ly_r == lyc_r), mode_s};
                4'h2:    reg_rdata_s = scy_r;
                4'h3:    reg_rdata_s = scx_r;
                4'h4:    reg_rdata_s = ly_r;
                4'h5:    reg_rdata_s = lyc_r;
                4'h7:    reg_rdata_s = bgp_r;
                4'h8:    reg_rdata_s = obp0_r;
                4'h9:    reg_rdata_s = obp1_r;
                4'hA:    reg_rdata_s = wy_r;
                4'hB:    reg_rdata_s = wx_r;
                default: begin
                    reg_rdata_s = 8'hFF;
                    reg_hit_s   = 1'b0;
                end
            endcase
        end else begin
            reg_rdata_s = 8'hFF;
            reg_hit_s   = 1'b0;
        end
    end

    // OAM/VRAM storage: the bus always has write access, contents survive reset.
    always_ff @(posedge clk) begin
        if (db_we && is_oam_s) oam_r[oam_idx_s] <= db_wdata;
        if (db_we && is_vram_s) vram_r[db_addr[12:0]] <= db_wdata;
    end

    // Bus read data; reads sample pre-write contents so a same-cycle write returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_rdata <= 8'hFF;
            db_hit   <= 1'b0;
        end else if (db_re) begin
            if (is_oam_s) begin
                db_rdata <= oam_r[oam_idx_s];
                db_hit   <= 1'b1;
            end else if (is_vram_s) begin
                db_rdata <= vram_r[db_addr[12:0]];
                db_hit   <= 1'b1;
            end else begin
                db_rdata <= reg_rdata_s;
                db_hit   <= reg_hit_s;
            end
        end
    end

    // LCD register writes; LY is owned by the timing logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcdc_r <= 8'h91;
            stat_r <= 4'd0;
            scy_r  <= 8'd0;
            scx_r  <= 8'd0;
            lyc_r  <= 8'd0;
            bgp_r  <= 8'hFC;
            obp0_r <= 8'd0;
            obp1_r <= 8'd0;
            wy_r   <= 8'd0;
            wx_r   <= 8'd0;
        end else if (db_we && is_reg_s) begin
            case (db_addr[3:0])
                4'h0:    lcdc_r <= db_wdata;
                4'h1:    stat_r <= db_wdata[6:3];
                4'h2:    scy_r  <= db_wdata;
                4'h3:    scx_r  <= db_wdata;
                4'h5:    lyc_r  <= db_wdata;
                4'h7:    bgp_r  <= db_wdata;
                4'h8:    obp0_r <= db_wdata;
                4'h9:    obp1_r <= db_wdata;
                4'hA:    wy_r   <= db_wdata;
                4'hB:    wx_r   <= db_wdata;
                default: ;
            endcase
        end
    end

    // Next dot/line position; a disabled LCD parks at the top-left.
    always_comb begin
        next_dot_s = 9'd0;
        next_ly_s  = 8'd0;
        if (lcdc_r[7]) begin
            if (dot_r == LAST_DOT) begin
                next_dot_s = 9'd0;
                next_ly_s  = (ly_r == LAST_LINE) ? 8'd0 : ly_r + 8'd1;
            end else begin
                next_dot_s = dot_r + 9'd1;
                next_ly_s  = ly_r;
            end
        end else begin
            next_dot_s = 9'd0;
            next_ly_s  = 8'd0;
        end
    end

    // Dot/line counters; pulses are computed from the next position so they line up with dot==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_r           <= 9'd0;
            ly_r            <= 8'd0;
            drawline        <= 1'b0;
            render_complete <= 1'b0;
        end else begin
            dot_r           <= next_dot_s;
            ly_r            <= next_ly_s;
            drawline        <= lcdc_r[7] && (next_dot_s == 9'd0) && (next_ly_s < VIS_LINES);
            render_complete <= lcdc_r[7] && (next_dot_s == 9'd0) && (next_ly_s == VIS_LINES);
        end
    end

    // STAT mode from the current position.
    always_comb begin
        mode_s = 2'd0;
        if (ly_r >= VIS_LINES) begin
            mode_s = 2'd1;
        end else if (dot_r < OAM_DOTS) begin
            mode_s = 2'd2;
        end else if (dot_r < DRAW_END) begin
            mode_s = 2'd3;
        end else begin
            mode_s = 2'd0;
        end
    end

    logic       pixel_on_s;
    logic [7:0] pix_x_s, bg_x_s, bg_y_s, tile_s, lo_s, hi_s;
    logic [12:0] map_addr_s, lo_addr_s, hi_addr_s;
    logic [8:0] tile_row_s;
    logic [2:0] bit_sel_s;
    logic [1:0] color_s, shade_s;

    assign pixel_on_s = lcdc_r[7] && (mode_s == 2'd3);
    assign pix_x_s    = dot_r[7:0] - 8'd80;
    assign bg_x_s     = pix_x_s + scx_r;
    assign bg_y_s     = ly_r + scy_r;
    assign map_addr_s = {(lcdc_r[3] ? 3'b111 : 3'b110), bg_y_s[7:3], bg_x_s[7:3]};
    assign tile_s     = vram_r[map_addr_s];
    // Signed mode: tiles 0..127 live at 9000, 128..255 at 8800.
    assign tile_row_s = lcdc_r[4] ? {1'b0, tile_s} : {~tile_s[7], tile_s[7], tile_s[6:0]};
    assign lo_addr_s  = {tile_row_s, bg_y_s[2:0], 1'b0};
    assign hi_addr_s  = {tile_row_s, bg_y_s[2:0], 1'b1};
    assign lo_s       = vram_r[lo_addr_s];
    assign hi_s       = vram_r[hi_addr_s];
    assign bit_sel_s  = 3'd7 - bg_x_s[2:0];
    assign color_s    = {hi_s[bit_sel_s], lo_s[bit_sel_s]};
    assign shade_s    = lcdc_r[0] ? pal_lookup(bgp_r, color_s) : 2'd0;

    // Pixel output register, one cycle behind the pixel dot.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_valid <= 1'b0;
            lcd_x     <= 8'd0;
            lcd_y     <= 8'd0;
            lcd_shade <= 2'd0;
        end else begin
            lcd_valid <= pixel_on_s;
            lcd_x     <= pix_x_s;
            lcd_y     <= ly_r;
            lcd_shade <= shade_s;
        end
    end

endmodule

// File: tb/tb_whiz_graphics.sv
// Directed-sequence bench for whiz_graphics with randomized data checked against a frame-level model.
module tb_whiz_graphics;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] db_addr;
    logic [7:0]  db_wdata;
    logic        db_we, db_re;
    logic [7:0]  db_rdata;
    logic        db_hit;
    logic        drawline, render_complete, lcd_valid;
    logic [7:0]  lcd_x, lcd_y;
    logic [1:0]  lcd_shade;

    int checks   = 0;
    int failures = 0;

    logic [7:0] oam_m  [0:255];
    logic [7:0] vram_m [0:8191];

    always #5 clk = ~clk;

    whiz_graphics dut (
        .clk(clk), .rst(rst),
        .db_addr(db_addr), .db_wdata(db_wdata), .db_we(db_we), .db_re(db_re),
        .db_rdata(db_rdata), .db_hit(db_hit),
        .drawline(drawline), .render_complete(render_complete),
        .lcd_valid(lcd_valid), .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_shade(lcd_shade)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        db_addr = a; db_wdata = d; db_we = 1'b1;
        @(posedge clk); #1;
        db_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
        db_addr = a; db_re = 1'b1;
        @(posedge clk); #1;
        db_re = 1'b0;
        d = db_rdata; h = db_hit;
    endtask

    function automatic logic [15:0] pick_reg(input int n);
        case (n)
            0: return 16'hFF42;
            1: return 16'hFF43;
            2: return 16'hFF45;
            3: return 16'hFF47;
            4: return 16'hFF48;
            5: return 16'hFF49;
            6: return 16'hFF4A;
            default: return 16'hFF4B;
        endcase
    endfunction

    // Background shade from the frame-level rules: 8000 tile addressing, 9800 map.
    function automatic logic [1:0] model_shade(input int x, input int y, input int scx, input int scy,
                                               input logic [7:0] pal);
        int bgx, bgy, tile, row_addr, b, c;
        logic [7:0] lo, hi;
        bgx = (x + scx) % 256;
        bgy = (y + scy) % 256;
        tile = vram_m[16'h1800 + (bgy / 8) * 32 + bgx / 8];
        row_addr = tile * 16 + (bgy % 8) * 2;
        lo = vram_m[row_addr];
        hi = vram_m[row_addr + 1];
        b = 7 - (bgx % 8);
        c = 2 * int'(hi[b]) + int'(lo[b]);
        return 2'((pal >> (2 * c)) & 8'd3);
    endfunction

    initial begin
        logic [7:0] rd, d, v, scx_rand, ly_wr;
        logic       h;
        logic [15:0] a;
        int t_prev, t_cur, dot_p, ly_p, dot_c, ly_c, n_draw, n_rc, mode_e;
        logic [7:0] reg_m [0:15];

        rst = 1'b1; db_addr = 16'h0000; db_wdata = 8'h00; db_we = 1'b0; db_re = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_drawline", drawline, 1'b0);
        check("rst_render", render_complete, 1'b0);
        check("rst_valid", lcd_valid, 1'b0);
        check("rst_rdata", {db_hit, db_rdata}, {1'b0, 8'hFF});
        rst = 1'b0;

        bus_read(16'hFF40, rd, h);
        check("lcdc_reset", {h, rd}, {1'b1, 8'h91});
        bus_read(16'hFF44, rd, h);
        check("ly_reset", {h, rd}, {1'b1, 8'h00});
        bus_read(16'hFF47, rd, h);
        check("bgp_reset", {h, rd}, {1'b1, 8'hFC});

        for (int i = 0; i < 900; i++) begin
            d = 8'($urandom);
            a = 16'hFE00 | 16'(i & 255);
            bus_write(a, d);
            oam_m[i & 255] = d;
            bus_read(a, rd, h);
            check("oam_rw", {h, rd}, {1'b1, d});
        end

        d = ~oam_m[16];
        db_addr = 16'hFE10; db_wdata = d; db_we = 1'b1; db_re = 1'b1;
        @(posedge clk); #1;
        db_we = 1'b0; db_re = 1'b0;
        check("same_cycle_old", {db_hit, db_rdata}, {1'b1, oam_m[16]});
        oam_m[16] = d;
        bus_read(16'hFE10, rd, h);
        check("same_cycle_new", rd, d);

        bus_write(16'h8000, 8'h5A);
        bus_write(16'h9FFF, 8'hA5);
        bus_read(16'h8000, rd, h);
        check("vram_8000", {h, rd}, {1'b1, 8'h5A});
        bus_read(16'h9FFF, rd, h);
        check("vram_9fff", {h, rd}, {1'b1, 8'hA5});
        bus_read(16'hFEFF, rd, h);
        check("oam_feff", {h, rd}, {1'b1, oam_m[255]});

        for (int i = 0; i < 24; i++) begin
            a = pick_reg(int'($urandom_range(0, 7)));
            d = 8'($urandom);
            bus_write(a, d);
            reg_m[a[3:0]] = d;
            bus_read(a, rd, h);
            check("reg_rw", {h, rd}, {1'b1, reg_m[a[3:0]]});
        end
        d = 8'($urandom);
        bus_write(16'hFF41, d);
        bus_read(16'hFF41, rd, h);
        check("stat_bits", {h, rd[6:3]}, {1'b1, d[6:3]});
        bus_read(16'hFF46, rd, h);
        check("unmapped_ff46", {h, rd}, {1'b0, 8'hFF});
        bus_read(16'hA000, rd, h);
        check("unmapped_a000", {h, rd}, {1'b0, 8'hFF});

        // Lines 0..7 background: map row 0 picks tiles 0/1, both with an all-3 top row.
        for (int i = 0; i < 32; i++) begin
            d = 8'($urandom_range(0, 1));
            bus_write(16'h9800 + 16'(i), d);
            vram_m[16'h1800 + i] = d;
        end
        for (int i = 0; i < 32; i++) begin
            d = ((i % 16) < 2) ? 8'hFF : 8'($urandom);
            bus_write(16'h8000 + 16'(i), d);
            vram_m[i] = d;
        end
        scx_rand = 8'($urandom);
        ly_wr = 8'($urandom);

        // Full frame from a fresh reset; k counts edges after the reset edge.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_draw = 0; n_rc = 0;
        for (int k = 1; k <= 70230; k++) begin
            db_we = 1'b0; db_re = 1'b0;
            if (k == 1) begin db_addr = 16'hFF45; db_wdata = 8'h0A; db_we = 1'b1; end
            else if (k == 2) begin db_addr = 16'hFF47; db_wdata = 8'hE4; db_we = 1'b1; end
            else if (k == 3) begin db_addr = 16'hFF43; db_wdata = scx_rand; db_we = 1'b1; end
            else if (k == 30001) begin db_addr = 16'hFF44; db_wdata = ly_wr; db_we = 1'b1; end
            else if (k >= 10 && k % 7 == 3) begin db_addr = 16'hFF41; db_re = 1'b1; end
            else if (k >= 10 && k % 7 == 5) begin db_addr = 16'hFF44; db_re = 1'b1; end
            @(posedge clk); #1;
            t_prev = (k - 1) % 70224; t_cur = k % 70224;
            dot_p = t_prev % 456; ly_p = t_prev / 456;
            dot_c = t_cur % 456;  ly_c = t_cur / 456;
            check("drawline", drawline, (dot_c == 0 && ly_c < 144));
            check("render_complete", render_complete, (dot_c == 0 && ly_c == 144));
            if (k <= 70224) begin
                n_draw += int'(drawline);
                n_rc   += int'(render_complete);
            end
            check("lcd_valid", lcd_valid, (ly_p < 144 && dot_p >= 80 && dot_p < 240));
            if (ly_p < 144 && dot_p >= 80 && dot_p < 240) begin
                check("lcd_xy", {lcd_x, lcd_y}, {8'(dot_p - 80), 8'(ly_p)});
                if (ly_p == 0) check("line0_shade3", lcd_shade, 2'd3);
                if (ly_p < 8)
                    check("lcd_shade", lcd_shade, model_shade(dot_p - 80, ly_p, int'(scx_rand), 0, 8'hE4));
            end
            if (db_re && db_addr == 16'hFF41) begin
                mode_e = (ly_p >= 144) ? 1 : (dot_p < 80) ? 2 : (dot_p < 240) ? 3 : 0;
                check("stat", {db_hit, db_rdata[6:0]}, {1'b1, 4'd0, (ly_p == 10), 2'(mode_e)});
            end
            if (db_re && db_addr == 16'hFF44)
                check("ly_read", {db_hit, db_rdata}, {1'b1, 8'(ly_p)});
        end
        db_re = 1'b0;
        check("drawline_count", n_draw, 144);
        check("render_count", n_rc, 1);

        bus_write(16'hFF40, 8'h11);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("off_pulses", {drawline, render_complete, lcd_valid}, 3'b000);
        end
        bus_read(16'hFF44, rd, h);
        check("off_ly", {h, rd}, {1'b1, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
